hack_boot_loader: RTL and testbench

- Sequences the Hack CPU at power-up and on demand: holds the CPU in reset, receives a program as a byte stream (UART/host side) and writes it into the instruction ROM/RAM, then releases the CPU.
- Sits between the host byte receiver, the instruction memory write port and the CPU `rst_n` input.
- Re-load at any time via `load_req`; the CPU is halted for the whole load.

---
 rtl/hack_boot_loader.sv | 199 +++++++++++++++++++
 tb/tb_hack_boot_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_boot_loader.sv
// Hack CPU boot loader: holds the CPU in reset, streams a big-endian program image into instruction memory, then releases it.
// Optional trailing 16-bit checksum verification is enabled by defining BOOT_CSUM_EN.
module hack_boot_loader #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_req_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  rom_we_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic [WIDTH-1:0]      rom_wdata_o,
  output logic                  cpu_rst_n_o,
  output logic                  load_done_o,
  output logic                  load_err_o
);

  localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

  typedef enum logic [3:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef BOOT_CSUM_EN
    S_CSUM_HI,
    S_CSUM_LO,
`endif
    S_DONE_WAIT,
    S_RUN,
    S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            hi_q, hi_d;
  logic                  rom_we_q, rom_we_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [WIDTH-1:0]      rom_wdata_q, rom_wdata_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;
`ifdef BOOT_CSUM_EN
  logic [15:0]           csum_q, csum_d;
`endif

  logic                  loading_c;
  logic                  accept_c;
  logic [15:0]           rx_word_c;
  logic [CNT_W-1:0]      cnt_inc_c;

  // Byte-consuming states; DONE_WAIT, RUN and ERR never take bytes.
  assign loading_c  = (state_q != S_DONE_WAIT) && (state_q != S_RUN) && (state_q != S_ERR);
  assign rx_ready_o = loading_c && !load_req_i;
  assign accept_c   = rx_valid_i && rx_ready_o;
  assign rx_word_c  = {hi_q, rx_data_i};
  assign cnt_inc_c  = cnt_q + CNT_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    hi_d        = hi_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
`ifdef BOOT_CSUM_EN
    csum_d      = csum_q;
`endif

    if (load_req_i) begin
      state_d = S_LEN_HI;
      cnt_d   = '0;
`ifdef BOOT_CSUM_EN
      csum_d  = '0;
`endif
    end else begin
      case (state_q)
        S_LEN_HI: begin
          if (accept_c) begin
            hi_d    = rx_data_i;
            state_d = S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept_c) begin
            len_d = rx_word_c;
            cnt_d = '0;
            if (rx_word_c == 16'd0) begin
`ifdef BOOT_CSUM_EN
              state_d = S_CSUM_HI;
`else
              state_d = S_RUN;
`endif
            end else if (32'(rx_word_c) > CAPACITY) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (accept_c) begin
            hi_d    = rx_data_i;
            state_d = S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (accept_c) begin
            rom_we_d    = 1'b1;
            rom_addr_d  = cnt_q[ADDR_WIDTH-1:0];
            rom_wdata_d = WIDTH'(rx_word_c);
            cnt_d       = cnt_inc_c;
`ifdef BOOT_CSUM_EN
            csum_d      = csum_q + rx_word_c;
`endif
            if (32'(cnt_inc_c) == 32'(len_q)) begin
`ifdef BOOT_CSUM_EN
              state_d = S_CSUM_HI;
`else
              state_d = S_DONE_WAIT;
`endif
            end else begin
              state_d = S_DATA_HI;
            end
          end
        end
`ifdef BOOT_CSUM_EN
        S_CSUM_HI: begin
          if (accept_c) begin
            hi_d    = rx_data_i;
            state_d = S_CSUM_LO;
          end
        end
        S_CSUM_LO: begin
          if (accept_c) begin
            state_d = (rx_word_c == csum_q) ? S_DONE_WAIT : S_ERR;
          end
        end
`endif
        S_DONE_WAIT: state_d = S_RUN;
        S_RUN:       state_d = S_RUN;
        S_ERR:       state_d = S_ERR;
        default:     state_d = S_LEN_HI;
      endcase
    end

    cpu_rst_n_d = (state_d == S_RUN);
    load_done_d = (state_d == S_RUN);
    load_err_d  = (state_d == S_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_LEN_HI;
      cnt_q       <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef BOOT_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
`ifdef BOOT_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rom_we_o    = rom_we_q;
  assign rom_addr_o  = rom_addr_q;
  assign rom_wdata_o = rom_wdata_q;
  assign cpu_rst_n_o = cpu_rst_n_q;
  assign load_done_o = load_done_q;
  assign load_err_o  = load_err_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Scoreboard bench for hack_boot_loader with a 16-word instruction memory; follows BOOT_CSUM_EN when defined.
module tb_hack_boot_loader;

  localparam int unsigned AW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_req;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;
  logic          cpu_rst_n;
  logic          load_done;
  logic          load_err;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  wr_t           exp_q[$];
  logic [AW-1:0] wr_addr;
  logic [15:0]   csum_acc;

  hack_boot_loader #(.WIDTH(16), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_req_i  (load_req),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .rx_ready_o  (rx_ready),
    .rom_we_o    (rom_we),
    .rom_addr_o  (rom_addr),
    .rom_wdata_o (rom_wdata),
    .cpu_rst_n_o (cpu_rst_n),
    .load_done_o (load_done),
    .load_err_o  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every write pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!rst && rom_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {28'd0, rom_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_addr", 32'(rom_addr), 32'(e.addr));
        check("we_data", 32'(rom_wdata), 32'(e.data));
        check("we_not_run", 32'(cpu_rst_n), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and hold it until accepted; rx_valid stays high afterwards.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic send_len(input logic [15:0] n);
    wr_addr  = '0;
    csum_acc = '0;
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [15:0] w);
    wr_t e;
    e.addr = wr_addr;
    e.data = w;
    exp_q.push_back(e);
    wr_addr  = wr_addr + AW'(1);
    csum_acc = csum_acc + w;
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_csum(input logic [15:0] c);
`ifdef BOOT_CSUM_EN
    send_byte(c[15:8]);
    send_byte(c[7:0]);
`else
    if (c == 16'hFFFF) csum_acc = c;
`endif
  endtask

  task automatic pulse_load_req();
    rx_valid = 1'b0;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    @(negedge clk);
    check("lreq_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("lreq_rx_ready", 32'(rx_ready), 32'd1);
    check("lreq_load_err", 32'(load_err), 32'd0);
    step();
  endtask

  // After the final accepted byte, the CPU must be released after exactly lat cycles.
  task automatic expect_run(input int lat, input string tag);
    rx_valid = 1'b0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check({tag, "_held"}, 32'(cpu_rst_n), 32'd0);
    end
    @(negedge clk);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    check({tag, "_load_done"}, 32'(load_done), 32'd1);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    check("rst_rom_we", 32'(rom_we), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_rom_wdata", 32'(rom_wdata), 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("idle_rx_ready", 32'(rx_ready), 32'd1);
    check("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("idle_load_done", 32'(load_done), 32'd0);
    step();

    // Two-word program.
    send_len(16'd2);
    send_word(16'h1234);
    send_word(16'hABCD);
    send_csum(16'hBE01);
    expect_run(2, "two_word");
    repeat (3) step();
    @(negedge clk);
    check("run_stable", 32'(cpu_rst_n), 32'd1);
    step();

    // Re-load request from RUN, then an empty program.
    pulse_load_req();
    send_len(16'd0);
`ifdef BOOT_CSUM_EN
    send_csum(16'h0000);
    expect_run(2, "empty");
`else
    expect_run(1, "empty");
`endif

    // Fill the whole memory to reach the last address.
    pulse_load_req();
    send_len(16'd16);
    for (int i = 0; i < 16; i++) send_word(16'(($urandom & 32'h0000_FFFF) ^ 32'(i)));
    send_csum(csum_acc);
    expect_run(2, "full");

    // Oversize length goes to ERR and is left only via load_req.
    pulse_load_req();
    send_len(16'd17);
    rx_valid = 1'b0;
    @(negedge clk);
    check("oversize_load_err", 32'(load_err), 32'd1);
    check("oversize_rx_ready", 32'(rx_ready), 32'd0);
    check("oversize_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    step();
    repeat (3) step();
    @(negedge clk);
    check("err_sticky", 32'(load_err), 32'd1);
    step();
    pulse_load_req();

    // Abort on a DATA_LO byte with rx_valid held high throughout.
    send_len(16'd3);
    send_word(16'h1122);
    send_byte(8'h33);
    rx_data  = 8'h44;
    load_req = 1'b1;
    @(negedge clk);
    check("abort_rx_ready", 32'(rx_ready), 32'd0);
    step();
    load_req = 1'b0;
    send_len(16'd1);
    send_word(16'h0007);
`ifdef BOOT_CSUM_EN
    send_csum(16'h0007);
`endif
    expect_run(2, "abort");

`ifdef BOOT_CSUM_EN
    // Wrong checksum lands in ERR; the matching one releases the CPU.
    pulse_load_req();
    send_len(16'd1);
    send_word(16'h0005);
    send_csum(16'h0006);
    rx_valid = 1'b0;
    @(negedge clk);
    check("csum_bad_err", 32'(load_err), 32'd1);
    check("csum_bad_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    step();
    repeat (2) step();
    @(negedge clk);
    check("csum_bad_held", 32'(cpu_rst_n), 32'd0);
    step();
    pulse_load_req();
    send_len(16'd1);
    send_word(16'h0005);
    send_csum(16'h0005);
    expect_run(2, "csum_ok");
`endif

    repeat (4) step();
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
